// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter
// Shares one 32x32 register-file read port among NUM_REQ requesters using a
// round-robin arbiter. The winner drives the port select in its grant cycle.
// The read data returns one cycle later on that requester's response lane.
// Optional feature macro: RFARB_R0_BYPASS_EN. When it is defined, reads of r0
// are answered locally with zero and take no part in arbitration.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 3
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [5*NUM_REQ-1:0]  req_addr,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [4:0]            ctrl_readReg,
  input  logic [31:0]           data_readReg,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [32*NUM_REQ-1:0] rsp_data
);

  // Per-requester view of the packed address bus
  logic [4:0]         addr_arr [NUM_REQ];
  // Requests answered locally (r0 bypass); all zero when the feature is off
  logic [NUM_REQ-1:0] bypass_vec;
  // Requests that compete for the shared read port
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               arb_found;
  logic [PTR_W-1:0]   arb_idx;
  logic [4:0]         sel_next;

  // Round-robin pointer: index of the most recent arbitrated winner
  logic [PTR_W-1:0]   last_gnt_reg;
  logic [PTR_W-1:0]   last_gnt_next;

  // Registered response state
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [31:0]        rsp_data_reg [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign addr_arr[gi] = req_addr[5*gi +: 5];
`ifdef RFARB_R0_BYPASS_EN
      assign bypass_vec[gi] = req[gi] && (addr_arr[gi] == 5'd0);
`else
      assign bypass_vec[gi] = 1'b0;
`endif
      assign rsp_data[32*gi +: 32] = rsp_data_reg[gi];
    end
  endgenerate

  assign arb_req = req & ~bypass_vec;

  // Round-robin search: scan upward from the slot after last_gnt, wrapping
  always_comb begin : search
    int cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_gnt   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_gnt_reg) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!arb_found && arb_req[j] && (cand == j)) begin
          arb_found  = 1'b1;
          arb_idx    = PTR_W'(j);
          arb_gnt[j] = 1'b1;
        end
      end
    end
  end

  // Read-port select follows the arbitrated winner; bypass grants never drive it
  always_comb begin
    sel_next = 5'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (arb_gnt[j]) sel_next = addr_arr[j];
    end
  end

  // Reset suppresses every grant, so nothing issued in a reset cycle is served
  assign gnt          = ctrl_reset ? '0 : (arb_gnt | bypass_vec);
  assign ctrl_readReg = ctrl_reset ? 5'd0 : sel_next;

  // Pointer moves only on an arbitrated grant
  assign last_gnt_next = arb_found ? arb_idx : last_gnt_reg;

  // Round-robin pointer register; requester 0 has top priority after reset
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      last_gnt_reg <= PTR_W'(NUM_REQ - 1);
    end else begin
      last_gnt_reg <= last_gnt_next;
    end
  end

  // Response lanes: pulse valid and capture data for every lane granted this cycle
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      rsp_valid_reg <= '0;
      for (int j = 0; j < NUM_REQ; j++) rsp_data_reg[j] <= '0;
    end else begin
      rsp_valid_reg <= arb_gnt | bypass_vec;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (arb_gnt[j]) begin
          rsp_data_reg[j] <= data_readReg;
        end else if (bypass_vec[j]) begin
          rsp_data_reg[j] <= 32'd0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_reg;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Testbench for regfile_read_arbiter (NUM_REQ=4).
// Each vector sets the inputs for one cycle and gives the expected combinational
// gnt and ctrl_readReg. The expected response for the next cycle is queued and
// checked after the following clock edge. Entries near the end of the table
// depend on whether RFARB_R0_BYPASS_EN is defined.
module tb_regfile_read_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            ctrl_reset;
  logic [N-1:0]    req;
  logic [5*N-1:0]  req_addr;
  logic [N-1:0]    gnt;
  logic [4:0]      ctrl_readReg;
  logic [31:0]     data_readReg;
  logic [N-1:0]    rsp_valid;
  logic [32*N-1:0] rsp_data;

  always #5 clk = ~clk;

  regfile_read_arbiter #(.NUM_REQ(N), .PTR_W(3)) dut (
    .clock(clk),
    .ctrl_reset(ctrl_reset),
    .req(req),
    .req_addr(req_addr),
    .gnt(gnt),
    .ctrl_readReg(ctrl_readReg),
    .data_readReg(data_readReg),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data)
  );

  // Register-file model: combinational read, r0 reads as zero
  logic [31:0] rf [32];
  assign data_readReg = rf[ctrl_readReg];

  typedef struct {
    string          name;
    logic           rst;
    logic [N-1:0]   req;
    logic [5*N-1:0] addr;
    logic [N-1:0]   gnt;
    logic [4:0]     sel;
  } vec_t;

  typedef struct {
    logic [N-1:0]    valid;
    logic [32*N-1:0] data;
  } rsp_t;

  vec_t            vecs[$];
  rsp_t            sb[$];
  logic [32*N-1:0] lane_model;
  int              n_cmp = 0;
  int              n_bad = 0;

  // Addresses per requester: {addr3, addr2, addr1, addr0}
  localparam logic [19:0] A  = {5'd11, 5'd7, 5'd5, 5'd3};
  localparam logic [19:0] A2 = {5'd11, 5'd9, 5'd5, 5'd3};
  localparam logic [19:0] A3 = {5'd11, 5'd7, 5'd9, 5'd0};

  function automatic vec_t mk(input string n, input logic r, input logic [N-1:0] q,
                              input logic [19:0] a, input logic [N-1:0] g,
                              input logic [4:0] s);
    vec_t v;
    v.name = n; v.rst = r; v.req = q; v.addr = a; v.gnt = g; v.sel = s;
    return v;
  endfunction

  // Checks the registered response against the oldest queued expectation
  task automatic check_rsp(input string tag);
    rsp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (rsp_valid !== e.valid) begin
        n_bad++;
        $display("FAIL rsp_valid after %s: got %b want %b", tag, rsp_valid, e.valid);
      end
      n_cmp++;
      if (rsp_data !== e.data) begin
        n_bad++;
        $display("FAIL rsp_data after %s: got %h want %h", tag, rsp_data, e.data);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string prev);
    rsp_t nx;
    @(posedge clk);
    #1;
    check_rsp(prev);
    ctrl_reset = v.rst;
    req        = v.req;
    req_addr   = v.addr;
    @(negedge clk);
    n_cmp++;
    if (gnt !== v.gnt) begin
      n_bad++;
      $display("FAIL gnt %s: got %b want %b", v.name, gnt, v.gnt);
    end
    n_cmp++;
    if (ctrl_readReg !== v.sel) begin
      n_bad++;
      $display("FAIL ctrl_readReg %s: got %0d want %0d", v.name, ctrl_readReg, v.sel);
    end
    if (v.rst) begin
      nx.valid   = '0;
      lane_model = '0;
    end else begin
      nx.valid = v.gnt;
      for (int i = 0; i < N; i++) begin
        if (v.gnt[i]) lane_model[32*i +: 32] = rf[v.addr[5*i +: 5]];
      end
    end
    nx.data = lane_model;
    sb.push_back(nx);
    $display("vec %-10s rst=%b req=%b gnt=%b sel=%0d", v.name, v.rst, v.req, gnt, ctrl_readReg);
  endtask

  initial begin
    string prev;
    ctrl_reset = 1'b1;
    req        = '0;
    req_addr   = '0;
    lane_model = '0;
    for (int i = 0; i < 32; i++) rf[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    rf[0] = 32'd0;
    rf[7] = 32'hDEAD_BEEF;

    vecs.push_back(mk("rst",      1, 4'b0000, A,  4'b0000, 5'd0));
    vecs.push_back(mk("rst",      1, 4'b0000, A,  4'b0000, 5'd0));
    vecs.push_back(mk("idle",     0, 4'b0000, A,  4'b0000, 5'd0));
    vecs.push_back(mk("idle",     0, 4'b0000, A,  4'b0000, 5'd0));
    vecs.push_back(mk("idle",     0, 4'b0000, A,  4'b0000, 5'd0));
    vecs.push_back(mk("single",   0, 4'b0100, A,  4'b0100, 5'd7));
    vecs.push_back(mk("idle",     0, 4'b0000, A,  4'b0000, 5'd0));
    vecs.push_back(mk("rst_req",  1, 4'b1111, A,  4'b0000, 5'd0));
    vecs.push_back(mk("rr0",      0, 4'b1111, A,  4'b0001, 5'd3));
    vecs.push_back(mk("rr1",      0, 4'b1111, A,  4'b0010, 5'd5));
    vecs.push_back(mk("rr2",      0, 4'b1111, A,  4'b0100, 5'd7));
    vecs.push_back(mk("rr3",      0, 4'b1111, A,  4'b1000, 5'd11));
    vecs.push_back(mk("rr0b",     0, 4'b1111, A,  4'b0001, 5'd3));
    vecs.push_back(mk("rr1b",     0, 4'b1111, A,  4'b0010, 5'd5));
    vecs.push_back(mk("pair",     0, 4'b1010, A,  4'b1000, 5'd11));
    vecs.push_back(mk("alone1",   0, 4'b0010, A,  4'b0010, 5'd5));
    vecs.push_back(mk("alone2",   0, 4'b0010, A,  4'b0010, 5'd5));
    vecs.push_back(mk("alone3",   0, 4'b0010, A,  4'b0010, 5'd5));
    vecs.push_back(mk("pre_rst",  0, 4'b0100, A,  4'b0100, 5'd7));
    vecs.push_back(mk("rst_mid",  1, 4'b0001, A,  4'b0000, 5'd0));
    vecs.push_back(mk("post_rst", 0, 4'b1111, A,  4'b0001, 5'd3));
    vecs.push_back(mk("hold",     0, 4'b0110, A,  4'b0010, 5'd5));
    vecs.push_back(mk("addr_chg", 0, 4'b0100, A2, 4'b0100, 5'd9));
    vecs.push_back(mk("idle",     0, 4'b0000, A,  4'b0000, 5'd0));
`ifdef RFARB_R0_BYPASS_EN
    vecs.push_back(mk("r0_byp",   0, 4'b0011, A3, 4'b0011, 5'd9));
    vecs.push_back(mk("byp_ptr",  0, 4'b1010, A3, 4'b1000, 5'd11));
`else
    vecs.push_back(mk("r0_arb",   0, 4'b0011, A3, 4'b0001, 5'd0));
    vecs.push_back(mk("r0_next",  0, 4'b0010, A3, 4'b0010, 5'd9));
`endif
    vecs.push_back(mk("idle",     0, 4'b0000, A,  4'b0000, 5'd0));

    prev = "start";
    foreach (vecs[i]) begin
      apply(vecs[i], prev);
      prev = vecs[i].name;
    end
    @(posedge clk);
    #1;
    check_rsp(prev);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Round-robin arbiter that shares one register-file read port between NUM_REQ requesters, e.g. decode, debug and writeback-check paths.
- Drives the read port's 5-bit select and captures the 32-bit read data.
- Returns the data to the winning requester one cycle after grant, on a per-requester response lane.
- Sits between the requesters and one read port of the 32x32 register file.

Parameters:
- NUM_REQ, 4, number of requesters. Legal range 2..8.
- PTR_W, 3, width of the round-robin pointer. Must satisfy 2^PTR_W >= NUM_REQ.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester read request. Level-held until granted.
- req_addr  in  5*NUM_REQ  register index per requester; requester i uses bits [5i+4:5i].
- gnt  out  NUM_REQ  one-hot grant, combinational, valid in the same cycle as req.
- ctrl_readReg  out  5  select to the register-file read port.
- data_readReg  in  32  combinational read data from the read port.
- rsp_valid  out  NUM_REQ  registered; bit i high for exactly one cycle per served request.
- rsp_data  out  32*NUM_REQ  registered read data; lane i uses bits [32i+31:32i].

Behaviour:
- Reset values:
  - rsp_valid = 0 and rsp_data = 0 on every lane.
  - Round-robin pointer last_gnt = NUM_REQ-1, so requester 0 has top priority after reset.
  - While ctrl_reset is high: gnt = 0 and ctrl_readReg = 0.
- Arbitration (combinational, each cycle):
  - Search req starting at index (last_gnt+1) mod NUM_REQ, wrapping upward.
  - The first set bit wins. gnt is one-hot, or all-zero if req == 0.
  - Handshake: a request is accepted in the cycle where req[i] && gnt[i].
  - Requester i must hold req[i] and its addr stable until that cycle.
  - Requester i may drop req[i] in the following cycle, or keep it high to request again.
- Port drive:
  - ctrl_readReg = req_addr of the granted requester.
  - ctrl_readReg = 5'd0 when there is no grant.
- Pointer update: on a clock edge with any grant, last_gnt <= granted index; otherwise it holds.
- Response, registered, latency 1:
  - At the edge ending grant cycle T, rsp_valid[i] <= 1 and lane i <= data_readReg for the granted i.
  - All other rsp_valid bits <= 0.
  - Non-served lanes keep their previous rsp_data.
  - rsp_valid[i] is high in cycle T+1 only.
- Throughput: one grant per cycle, back-to-back allowed, including the same requester when it is alone.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles.
- Register 0: the read data is passed through unmodified. The register file is responsible for reading r0 as zero.
- Reset mid-operation:
  - A grant pending in the reset cycle is cancelled; no rsp_valid follows it.
  - A response already registered is cleared on that edge.
- An addr change while req is held but not yet granted: the value present in the grant cycle is the one used.

Optional Feature:
- Macro: RFARB_R0_BYPASS_EN.
- Defined:
  - A requester with req[i]=1 and req_addr=0 is excluded from arbitration and gets gnt[i]=1 in the same cycle.
  - It receives rsp_valid[i]=1 and rsp_data lane i = 0 at T+1, without driving ctrl_readReg.
  - Several bypasses plus one arbitrated grant may complete in the same cycle.
  - Bypass grants do not move last_gnt.
- Undefined: r0 requests arbitrate like any other address.

Test Plan:
- Reset, then release with req=0 -> gnt=0, ctrl_readReg=0, rsp_valid=0 for 3 cycles.
- Single requester: req=4'b0100, addr2=5'd7, regfile r7=32'hDEADBEEF -> gnt=4'b0100 and ctrl_readReg=7 in cycle T; rsp_valid=4'b0100 and lane2=32'hDEADBEEF at T+1.
- All four requesting continuously after reset -> grant order 0,1,2,3,0,1. Each rsp_valid lane carries the data of its own addr one cycle after its grant.
- req=4'b1010 with last_gnt=1 -> grant 3 first, then 1. Dropping req[3] after its grant -> requester 1 is granted alone on consecutive cycles.
- ctrl_reset asserted in a cycle with gnt=4'b0001 -> no rsp_valid at the next cycle. After release, requester 0 wins first.
- With RFARB_R0_BYPASS_EN: req=4'b0011, addr0=0, addr1=5'd9 -> gnt=4'b0011 and ctrl_readReg=9. At T+1, rsp_valid=4'b0011, lane0=0 and lane1=r9.
